enc_codeword_gen_32bit: RTL and testbench

Pipelined encoder producing 32-bit extended-Hamming (SEC-DED) codewords from 26-bit data words. It is the transmit-side counterpart of the 32-bit decoder syndrome path: every codeword it emits yields an all-zero 6-bit syndrome in the decoder. It sits between the data source and the channel model, uses valid/ready handshakes on both sides, and offers per-word error injection for decoder verification.

---
 rtl/enc_dec_defs_pkg.sv | 56 +++++
 rtl/enc_parity_calc_32bit.sv | 17 +
 rtl/enc_codeword_gen_32bit.sv | 96 +++++++++
 tb/tb_enc_codeword_gen_32bit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_dec_defs_pkg.sv
// Shared SEC-DED definitions for the 32-bit extended-Hamming encoder and decoder:
// parity masks, widths, parity bit positions and the codeword assembly helpers.
package enc_dec_defs_pkg;

  localparam int DATA_W   = 26;
  localparam int CW_W     = 32;
  localparam int PAR_W    = 6;
  localparam int CNT_W    = 16;
  localparam int DATA_LSB = 6;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P3_POS = 3;
  localparam int P4_POS = 4;
  localparam int P5_POS = 5;

  // Each mask selects the data positions covered by one Hamming parity bit
  localparam logic [CW_W-1:0] MASK0 = 32'hAAAB56C0;
  localparam logic [CW_W-1:0] MASK1 = 32'hCCCD9B40;
  localparam logic [CW_W-1:0] MASK2 = 32'hF0F1E380;
  localparam logic [CW_W-1:0] MASK3 = 32'hFF01FC00;
  localparam logic [CW_W-1:0] MASK4 = 32'hFFFE0000;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  par;
    logic [CW_W-1:0]   inj;
  } s1_word_t;

  function automatic logic [4:0] hamming_par(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] c;
    logic [4:0]      p;
    c = {data, {DATA_LSB{1'b0}}};
    p = '0;
    p[P0_POS] = ^(c & MASK0);
    p[P1_POS] = ^(c & MASK1);
    p[P2_POS] = ^(c & MASK2);
    p[P3_POS] = ^(c & MASK3);
    p[P4_POS] = ^(c & MASK4);
    return p;
  endfunction

  function automatic logic [CW_W-1:0] assemble_cw(input logic [DATA_W-1:0] data,
                                                  input logic [PAR_W-1:0]  par);
    logic [CW_W-1:0] cw;
    cw = '0;
    cw[CW_W-1:DATA_LSB] = data;
    cw[P5_POS]          = par[P5_POS];
    cw[P4_POS:P0_POS]   = par[P4_POS:P0_POS];
    return cw;
  endfunction

endpackage

// File: rtl/enc_parity_calc_32bit.sv
// Combinational SEC-DED parity generator: five Hamming bits plus the overall
// even-parity bit that covers data and the Hamming bits together.
module enc_parity_calc_32bit
  import enc_dec_defs_pkg::*;
(
  input  logic [25:0] data,
  output logic [5:0]  parity
);

  logic [4:0] ham_par;

  always_comb begin
    ham_par = hamming_par(data);
    parity  = {^{data, ham_par}, ham_par};
  end

endmodule

// File: rtl/enc_codeword_gen_32bit.sv
// Two-stage valid/ready SEC-DED encoder with per-word error injection and a
// saturating count of delivered codewords.
module enc_codeword_gen_32bit
  import enc_dec_defs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] in_data,
  input  logic [31:0] in_inj_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_codeword,
  output logic [15:0] word_cnt
);

  logic        s1_v_q, s1_v_d;
  s1_word_t    s1_word_q, s1_word_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_cw_q, out_cw_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic [5:0]  par_calc;
  logic        s2_accept;
  logic        in_fire;
  logic        s1_to_s2;
  logic        out_fire;

  enc_parity_calc_32bit u_parity (
    .data   (in_data),
    .parity (par_calc)
  );

  // Handshake decisions; a full pipeline still advances when the sink takes a word
  always_comb begin
    s2_accept = !out_valid_q || out_ready;
    in_ready  = !s1_v_q || s2_accept;
    in_fire   = in_valid && in_ready;
    s1_to_s2  = s1_v_q && s2_accept;
    out_fire  = out_valid_q && out_ready;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_word_d = s1_word_q;
    if (in_fire) begin
      s1_v_d         = 1'b1;
      s1_word_d.data = in_data;
      s1_word_d.par  = par_calc;
      s1_word_d.inj  = in_inj_mask;
    end else if (s1_to_s2) begin
      s1_v_d = 1'b0;
    end
  end

  // Injection is applied to the finished codeword so P5 reflects clean data
  always_comb begin
    out_valid_d = out_valid_q;
    out_cw_d    = out_cw_q;
    if (s1_to_s2) begin
      out_valid_d = 1'b1;
      out_cw_d    = assemble_cw(s1_word_q.data, s1_word_q.par) ^ s1_word_q.inj;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (out_fire && (word_cnt_q != CNT_MAX)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_word_q   <= '0;
      out_valid_q <= 1'b0;
      out_cw_q    <= '0;
      word_cnt_q  <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_word_q   <= s1_word_d;
      out_valid_q <= out_valid_d;
      out_cw_q    <= out_cw_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_codeword = out_cw_q;
  assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_enc_codeword_gen_32bit.sv
// Self-checking bench for enc_codeword_gen_32bit: a queue-based reference model
// checked every cycle, plus directed vectors with hand-computed codewords.
`timescale 1ns/1ps
module tb_enc_codeword_gen_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_data;
  logic [31:0] in_inj_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_codeword;
  logic [15:0] word_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] HMASK [5] = '{32'hAAAB56C0, 32'hCCCD9B40, 32'hF0F1E380,
                                        32'hFF01FC00, 32'hFFFE0000};

  logic [31:0] exp_q [$];
  logic [31:0] msk_q [$];
  int          model_cnt;
  logic        stall_prev;
  logic [31:0] stall_cw;

  enc_codeword_gen_32bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_inj_mask  (in_inj_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .word_cnt     (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference codeword: parity counts over the masked data, then even parity overall
  function automatic logic [31:0] model_cw(input logic [25:0] d, input logic [31:0] m);
    logic [31:0] c;
    c = {d, 6'b000000};
    for (int i = 0; i < 5; i++) c[i] = ($countones(c & HMASK[i]) % 2) == 1;
    c[5] = ($countones(c) % 2) == 1;
    return c ^ m;
  endfunction

  function automatic logic [5:0] syndrome(input logic [31:0] cw);
    logic [5:0] s;
    for (int i = 0; i < 5; i++) s[i] = (($countones(cw & HMASK[i]) + int'(cw[i])) % 2) == 1;
    s[5] = ($countones(cw) % 2) == 1;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      msk_q.delete();
      model_cnt  = 0;
      stall_prev = 1'b0;
    end else begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < 2) || out_ready});
      checkOutput("word_cnt", {16'b0, word_cnt}, model_cnt);
      if (stall_prev) begin
        checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("stall_cw", out_codeword, stall_cw);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL spurious_out: got %h expected no word at %0t", out_codeword, $time);
        end else begin
          logic [31:0] e, m;
          e = exp_q.pop_front();
          m = msk_q.pop_front();
          checkOutput("out_cw", out_codeword, e);
          if (m == 32'd0) checkOutput("syndrome", {26'b0, syndrome(out_codeword)}, 32'd0);
          if (model_cnt < 65535) model_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_cw(in_data, in_inj_mask));
        msk_q.push_back(in_inj_mask);
      end
      stall_prev = out_valid && !out_ready;
      stall_cw   = out_codeword;
    end
  end

  // Offer one word to a drained pipeline and return its codeword and edge latency
  task automatic applyStimulus(input logic [25:0] d, input logic [31:0] m, output logic [31:0] cw);
    int edges;
    bit seen;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_inj_mask = m; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1; seen = 1'b0; cw = '0;
    while (!seen && edges < 10) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        cw = out_codeword;
      end else begin
        @(posedge clk);
        edges++;
      end
    end
    checkOutput("latency", edges, 32'd2);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] cw;
    logic [25:0] vals [3];
    logic [31:0] got [3];
    int          got_cyc [3];
    int          n_got, accepted, tries;
    logic [25:0] bp [3];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inj_mask = '0; out_ready = 1'b1;

    checkOutput("model_pin_1", model_cw(26'h1, 32'h0), 32'h00000063);
    checkOutput("model_pin_2", model_cw(26'h2, 32'h0), 32'h000000A5);
    checkOutput("model_pin_ff", model_cw(26'h3FFFFFF, 32'h0), 32'hFFFFFFFF);
    checkOutput("model_syn_single", {26'b0, syndrome(32'h00000080)}, 32'h25);

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_cw", out_codeword, 32'd0);
    checkOutput("rst_word_cnt", {16'b0, word_cnt}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(26'h0, 32'h0, cw);
    checkOutput("zero_word", cw, 32'h00000000);
    @(negedge clk);
    checkOutput("cnt_after_one", {16'b0, word_cnt}, 32'd1);

    vals[0] = 26'h1; vals[1] = 26'h2; vals[2] = 26'h3FFFFFF;
    n_got = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_inj_mask = '0;
      if (cyc < 3) begin
        in_valid = 1'b1; in_data = vals[cyc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && n_got < 3) begin
        got[n_got] = out_codeword; got_cyc[n_got] = cyc; n_got++;
      end
    end
    checkOutput("b2b_count", n_got, 32'd3);
    if (n_got == 3) begin
      checkOutput("b2b_w1", got[0], 32'h00000063);
      checkOutput("b2b_w2", got[1], 32'h000000A5);
      checkOutput("b2b_w3", got[2], 32'hFFFFFFFF);
      checkOutput("b2b_consecutive", got_cyc[2] - got_cyc[0], 32'd2);
    end

    applyStimulus(26'h0, 32'h00000080, cw);
    checkOutput("inj_single_cw", cw, 32'h00000080);
    checkOutput("inj_single_syn", {26'b0, syndrome(cw)}, 32'h25);
    applyStimulus(26'h0, 32'h000000C0, cw);
    checkOutput("inj_double_cw", cw, 32'h000000C0);
    checkOutput("inj_double_s5", {31'b0, syndrome(cw) >> 5}, 32'd0);
    checkOutput("inj_double_nz", {31'b0, syndrome(cw) != 6'd0}, 32'd1);

    bp[0] = 26'h1555555; bp[1] = 26'h0AAAAAA; bp[2] = 26'h1234567;
    accepted = 0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = bp[0]; in_inj_mask = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk); #1;
      if (accepted < 3) in_data = bp[accepted];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("bp_accepted", accepted, 32'd2);
    checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_head", out_codeword, model_cw(bp[0], 32'h0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    tries = 0;
    while (accepted < 3 && tries < 10) begin
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    checkOutput("bp_third_taken", accepted, 32'd3);
    repeat (5) @(negedge clk);
    checkOutput("bp_drained", exp_q.size(), 32'd0);

    accepted = 0;
    for (int cyc = 0; cyc < 20000 && accepted < 1500; cyc++) begin
      @(posedge clk); #1;
      in_valid    = ($urandom_range(0, 99) < 70);
      in_data     = 26'($urandom);
      in_inj_mask = '0;
      out_ready   = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
    end
    checkOutput("rand_accepted", accepted, 32'd1500);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rand_drained", exp_q.size(), 32'd0);

    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 26'h0ABCDEF;
    @(posedge clk); #1;
    in_data = 26'h0FEDCBA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_word_cnt", {16'b0, word_cnt}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(26'h2, 32'h0, cw);
    checkOutput("postrst_word", cw, 32'h000000A5);

    pulseReset();
    @(posedge clk); #1;
    out_ready = 1'b1; in_inj_mask = '0; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 26'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("cnt_saturated", {16'b0, word_cnt}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
